fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction-fetch stage directly upstream of the control decoder: owns the PC, fetches from instruction memory over a req/ack handshake, presents instrucao.
// - Consumes Branch/Jump/jr_sel back from the decoder and datapath to compute the next PC.
// - Supplies pc_plus4 as the JAL link value.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC loaded on reset
// - TIMEOUT   16             max cycles imem_ack may stay low in FETCH before error; 0 = no timeout
// - PERF_W    32             width of performance counters (only with FETCH_PERF_CNT_EN)
// PORTS
// - clock        in   1   single clock, all state updates on posedge
// - reset        in   1   synchronous, active-high
// - imem_req     out  1   fetch request to instruction memory
// - imem_addr    out  32  fetch address (= pc)
// - imem_ack     in   1   memory returns imem_rdata this cycle
// - imem_rdata   in   32  fetched instruction word
// - instrucao    out  32  instruction to decoder, registered
// - instr_valid  out  1   instrucao valid, executing
// - instr_done   in   1   datapath finished current instruction
// - stall        in   1   hold current instruction / PC
// - Branch       in   1   from decoder
// - br_cond      in   1   ALU branch condition true (BEQ/BNE already resolved)
// - Jump         in   1   from decoder
// - jr_sel       in   1   from decoder, jump target = rs_data
// - rs_data      in   32  register rs value, JR target
// - pc           out  32  current PC
// - pc_plus4     out  32  pc + 4, JAL link value
// - misalign     out  1   one-cycle pulse: JR target low 2 bits nonzero
// - fetch_err    out  1   sticky: ack timeout
// BEHAVIOUR
// - Reset values: pc=RESET_PC, state=FETCH, imem_req=0, instrucao=0, instr_valid=0, misalign=0, fetch_err=0, wait counter=0.
// - imem_req is registered: asserted from the first cycle after reset deassertion.
// - reset dominates every input: ack/done in a reset cycle are ignored, and an in-flight fetch is abandoned.
// - State FETCH:
//   - imem_req=1, imem_addr=pc.
//   - On imem_ack: instrucao<=imem_rdata, instr_valid<=1, imem_req<=0, go EXEC.
//   - Otherwise wait counter++.
//   - If TIMEOUT!=0 and counter reaches TIMEOUT with no ack: fetch_err<=1, go HALT.
// - State EXEC:
//   - instrucao and instr_valid held stable.
//   - When instr_done=1 and stall=0: pc<=next_pc, instr_valid<=0, counter<=0, go FETCH.
//   - stall=1 freezes pc and instrucao regardless of instr_done.
//   - imem_ack in EXEC is ignored.
// - State HALT: imem_req=0, instr_valid=0, pc frozen; leaves only via reset.
// - Latency: minimum 2 cycles per instruction (1 FETCH with same-cycle ack + 1 EXEC).
// - next_pc priority, evaluated in EXEC:
//   - Jump&jr_sel -> {rs_data[31:2],2'b00}; misalign pulses if rs_data[1:0]!=0.
//   - Jump -> {pc_plus4[31:28], instrucao[25:0], 2'b00}.
//   - Branch&br_cond -> pc_plus4 + ({{14{instrucao[15]}}, instrucao[15:0], 2'b00}).
//   - else -> pc_plus4.
// - All PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0; negative branch offsets wrap likewise.
// - pc_plus4 is combinational from pc.
// - Branch with br_cond=0 is sequential.
// - Branch and Jump both high: Jump wins.
// CONFIGURATION
// - Macro FETCH_PERF_CNT_EN.
// - Defined: adds outputs perf_fetch[PERF_W-1:0] and perf_redirect[PERF_W-1:0].
//   - Both reset to 0 and saturate at all-ones.
//   - perf_fetch increments on each accepted imem_ack in FETCH.
//   - perf_redirect increments on each EXEC->FETCH transition whose next_pc != pc_plus4.
// - Undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
// - Reset then ack every cycle, instr_done=1 -> imem_addr sequence 0,4,8,C; instr_valid alternates 0/1.
// - In EXEC with instrucao=32'h1000_FFFF, pc=0x40, Branch=1, br_cond=1 -> next fetch addr 0x40.
// - pc=0x100, Jump=1, jr_sel=1, rs_data=0x207 -> next addr 0x204 and misalign pulses 1 cycle.
// - Withhold imem_ack for 16 cycles (TIMEOUT=16) -> fetch_err=1, imem_req=0; assert reset -> fetch_err=0, pc=RESET_PC.
// - EXEC with stall=1, instr_done=1 for 5 cycles -> pc and instrucao unchanged; drop stall -> advance next cycle.
// - pc=32'hFFFF_FFFC sequential -> next addr 0; reset asserted while in FETCH with ack=1 -> instrucao stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage ahead of the control decoder.
// Owns the PC, fetches over an imem req/ack handshake, holds the fetched
// word for the datapath, and computes the next PC from Branch/Jump/jr_sel.
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// perf_fetch / perf_redirect counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          PERF_W   = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrucao,
  output logic        instr_valid,
  input  logic        instr_done,
  input  logic        stall,
  input  logic        Branch,
  input  logic        br_cond,
  input  logic        Jump,
  input  logic        jr_sel,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign,
  output logic        fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_fetch,
  output logic [PERF_W-1:0] perf_redirect
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Wait counter only needs to reach TIMEOUT-1; the halt fires on that cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

  state_t           state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [31:0]      next_pc;
  logic [31:0]      br_off;
  logic             jr_bad;
  logic             ack_take;
  logic             exec_leave;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign br_off    = {{14{instrucao[15]}}, instrucao[15:0], 2'b00};

  // An ack only counts while a request is actually outstanding in FETCH.
  assign ack_take   = (state_reg == FETCH) && imem_req && imem_ack;
  assign exec_leave = (state_reg == EXEC) && instr_done && !stall;

  // Next-PC selection: JR beats J beats taken branch beats sequential.
  always_comb begin
    next_pc = pc_plus4;
    jr_bad  = 1'b0;
    if (Jump && jr_sel) begin
      next_pc = {rs_data[31:2], 2'b00};
      jr_bad  = |rs_data[1:0];
    end else if (Jump) begin
      next_pc = {pc_plus4[31:28], instrucao[25:0], 2'b00};
    end else if (Branch && br_cond) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // Fetch FSM with all outputs registered; reset overrides every input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= FETCH;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      instrucao    <= 32'h0;
      instr_valid  <= 1'b0;
      misalign     <= 1'b0;
      fetch_err    <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      misalign <= 1'b0;
      case (state_reg)
        FETCH: begin
          if (!imem_req) begin
            // First cycle out of reset: raise the request, nothing to accept yet.
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instrucao    <= imem_rdata;
            instr_valid  <= 1'b1;
            imem_req     <= 1'b0;
            wait_cnt_reg <= '0;
            state_reg    <= EXEC;
          end else if ((TIMEOUT != 0) && (wait_cnt_reg == TO_LAST)) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state_reg <= HALT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        EXEC: begin
          if (exec_leave) begin
            pc           <= next_pc;
            instr_valid  <= 1'b0;
            wait_cnt_reg <= '0;
            imem_req     <= 1'b1;
            misalign     <= jr_bad;
            state_reg    <= FETCH;
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state_reg   <= HALT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic redirect;
  assign redirect = exec_leave && (next_pc != pc_plus4);

  // Saturating counts of accepted fetches and non-sequential PC updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch    <= '0;
      perf_redirect <= '0;
    end else begin
      if (ack_take && !(&perf_fetch)) begin
        perf_fetch <= perf_fetch + PERF_W'(1);
      end
      if (redirect && !(&perf_redirect)) begin
        perf_redirect <= perf_redirect + PERF_W'(1);
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ack_take;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default build, TIMEOUT=16).
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instrucao;
  logic        instr_valid;
  logic        instr_done;
  logic        stall;
  logic        Branch;
  logic        br_cond;
  logic        Jump;
  logic        jr_sel;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16),
    .PERF_W  (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instrucao  (instrucao),
    .instr_valid(instr_valid),
    .instr_done (instr_done),
    .stall      (stall),
    .Branch     (Branch),
    .br_cond    (br_cond),
    .Jump       (Jump),
    .jr_sel     (jr_sel),
    .rs_data    (rs_data),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .misalign   (misalign),
    .fetch_err  (fetch_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for an outstanding request, then return one word with a same-cycle ack.
  task automatic do_fetch(input logic [31:0] word);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    $display("[TB] fetch addr=%h word=%h", imem_addr, word);
    check("fetch_valid", {31'b0, instr_valid}, 32'd1);
    check("fetch_instr", instrucao, word);
  endtask

  // Finish the current instruction with the given control inputs for one cycle.
  task automatic do_exec(input logic br, input logic cond, input logic j,
                         input logic jr, input logic [31:0] rs);
    Branch = br; br_cond = cond; Jump = j; jr_sel = jr; rs_data = rs;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    Branch = 1'b0; br_cond = 1'b0; Jump = 1'b0; jr_sel = 1'b0; rs_data = 32'h0;
    $display("[TB] exec br=%b cond=%b j=%b jr=%b rs=%h -> pc=%h", br, cond, j, jr, rs, pc);
    check("exec_valid_clr", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    instr_done = 1'b1; stall = 1'b0; Branch = 1'b0; br_cond = 1'b0;
    Jump = 1'b0; jr_sel = 1'b0; rs_data = 32'h0;
    tick(); tick(); tick();
    // Reset state, with ack/done active to show they are ignored under reset.
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr", instrucao, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);

    // Ack every cycle, done every cycle: 0,4,8,C with valid alternating.
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 32'h2000_0000 + i;
      check("seq_addr", imem_addr, 32'(4 * i));
      check("seq_req", {31'b0, imem_req}, 32'd1);
      check("seq_valid0", {31'b0, instr_valid}, 32'd0);
      tick();
      check("seq_valid1", {31'b0, instr_valid}, 32'd1);
      check("seq_instr", instrucao, 32'h2000_0000 + i);
      $display("[TB] seq fetch %0d addr=%h instr=%h", i, imem_addr, instrucao);
      tick();
    end
    imem_ack = 1'b0; instr_done = 1'b0;
    check("seq_pc_end", pc, 32'h10);

    // J to 0x40: {0x14[31:28], 26'h10, 2'b00}.
    do_fetch(32'h0800_0010);
    do_exec(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("j_pc", pc, 32'h40);
    // Taken branch with offset -1 word: 0x44 - 4 = 0x40.
    do_fetch(32'h1000_FFFF);
    do_exec(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("br_taken_addr", imem_addr, 32'h40);
    // Not-taken branch falls through.
    do_fetch(32'h1000_FFFF);
    do_exec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("br_nt_addr", imem_addr, 32'h44);
    // Branch and Jump together: jump target 0x80 wins over branch 0xC8.
    do_fetch(32'h0800_0020);
    do_exec(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("br_j_prio", pc, 32'h80);

    // JR aligned to 0x100, then misaligned 0x207 -> 0x204 with a single misalign pulse.
    do_fetch(32'h0000_0008);
    do_exec(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    check("jr_pc", pc, 32'h100);
    check("jr_no_misalign", {31'b0, misalign}, 32'd0);
    do_fetch(32'h0000_0008);
    do_exec(1'b0, 1'b0, 1'b1, 1'b1, 32'h207);
    check("jr_mis_addr", imem_addr, 32'h204);
    check("jr_misalign_hi", {31'b0, misalign}, 32'd1);
    tick();
    check("jr_misalign_lo", {31'b0, misalign}, 32'd0);

    // Stall holds EXEC for 5 cycles despite instr_done.
    do_fetch(32'hDEAD_BEEF);
    stall = 1'b1; instr_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", pc, 32'h204);
      check("stall_instr", instrucao, 32'hDEAD_BEEF);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      $display("[TB] stall cycle %0d pc=%h", i, pc);
    end
    stall = 1'b0;
    tick();
    instr_done = 1'b0;
    check("unstall_pc", pc, 32'h208);
    check("unstall_valid", {31'b0, instr_valid}, 32'd0);

    // PC wrap: FFFF_FFFC + 4 = 0.
    do_fetch(32'h1234_5678);
    do_exec(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    do_fetch(32'h1234_5678);
    do_exec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset while FETCH is requesting and ack is high: word is discarded.
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    check("rstack_instr", instrucao, 32'h0);
    check("rstack_valid", {31'b0, instr_valid}, 32'd0);
    check("rstack_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("rstack_instr2", instrucao, 32'h0);
    $display("[TB] reset with ack instr=%h", instrucao);
    reset = 1'b0; imem_ack = 1'b0;

    // Timeout from pc=0x300: 16 request cycles without ack -> HALT with sticky error.
    do_fetch(32'h0800_00C0);
    do_exec(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("to_pc", pc, 32'h300);
    n = 0;
    while (fetch_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    $display("[TB] timeout after %0d cycles", n);
    check("to_cycles", 32'(n), 32'd16);
    check("to_err", {31'b0, fetch_err}, 32'd1);
    check("to_req", {31'b0, imem_req}, 32'd0);
    check("to_pc_frozen", pc, 32'h300);
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick(); tick();
    imem_ack = 1'b0;
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_valid", {31'b0, instr_valid}, 32'd0);
    check("halt_instr", instrucao, 32'h0800_00C0);
    check("halt_err", {31'b0, fetch_err}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("clr_err", {31'b0, fetch_err}, 32'd0);
    check("clr_pc", pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
